// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type, line levels and parity helper for tx/rx blocks.
// ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;
`endif
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   // Zero-extended words leave the XOR unchanged, so any width up to 9 fits.
   function automatic logic parity(input logic [8:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-time counter, 0..BIT_CYCLES-1 while enabled, held at 0 otherwise,
// with a one-cycle tick on the last clock of each bit.
module uart_baud_gen #(
   parameter int BIT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tick_o
);
   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   assign tick_o = en_i && (cnt_q == LAST);
   always_comb cnt_d = (!en_i || tick_o) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: UART frame serializer (start, LSB-first data, optional parity, stop bits).
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop.
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 rs232_tx
);
   localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   if (BIT_CYCLES < 2 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
      $error("uart_frame_tx: illegal parameter set");
   end

   tx_state_e state_q, state_d;
   logic [3:0] bit_q, bit_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic line_q, line_d, done_q, done_d, rdy_q, tick, accept;

   // rdy_q keeps tx_ready low through the reset cycle itself.
   assign tx_ready = rdy_q && (state_q == ST_IDLE);
   assign tx_busy  = state_q != ST_IDLE;
   assign tx_done  = done_q;
   assign rs232_tx = line_q;
   assign accept   = tx_valid && tx_ready;

   uart_baud_gen #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .en_i  (tx_busy),
      .tick_o(tick)
   );

`ifdef UART_TX_PARITY_EN
   logic par_q, par_d;
   assign par_d = accept ? parity(9'(tx_data), 1'(PARITY_ODD)) : par_q;
   always_ff @(posedge clk_in) par_q <= rst_in ? 1'b0 : par_d;
`endif

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: if (accept) begin
            state_d = ST_START;
            data_d  = tx_data;
         end
         ST_START: if (tick) state_d = ST_DATA;
         ST_DATA: if (tick) begin
            data_d = data_q >> 1;
            if (bit_q == LAST_DATA) begin
               bit_d = '0;
`ifdef UART_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end else bit_d = bit_q + 1'b1;
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (tick) state_d = ST_STOP;
`endif
         ST_STOP: if (tick) begin
            if (bit_q == LAST_STOP) begin
               state_d = ST_IDLE;
               bit_d   = '0;
               done_d  = 1'b1;
            end else bit_d = bit_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      // Line level follows the next state so rs232_tx changes on the same edge as the FSM.
`ifdef UART_TX_PARITY_EN
      line_d = (state_d == ST_START) ? START_BIT : (state_d == ST_DATA) ? data_d[0] :
               (state_d == ST_PARITY) ? par_q : STOP_BIT;
`else
      line_d = (state_d == ST_START) ? START_BIT : (state_d == ST_DATA) ? data_d[0] : STOP_BIT;
`endif
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         bit_q   <= '0;
         data_q  <= '0;
         line_q  <= STOP_BIT;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         line_q  <= line_d;
         done_q  <= done_d;
         rdy_q   <= 1'b1;
      end
   end
endmodule
